// File: rtl/exc_commit_unit.sv
// exc_commit_unit
//   Writeback-stage exception arbiter and pipeline redirector.
//   Picks the single highest-priority exception (or ERET) carried by the
//   committing instruction, pulses it to CP0 one cycle later, flushes the
//   younger pipeline stages and offers the new fetch PC over a valid/ready
//   handshake until fetch accepts it.
//
//   Optional feature macro: EXC_INT_EN
//     defined   -> has_int is arbitrated as the highest-priority exception
//     undefined -> has_int is ignored, ExcCode 0x00 is never produced
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   ws_*               committing instruction: valid, pc, delay-slot flag,
//                      exception flags, ERET, faulting data address
//   has_int, epc       CP0 pending interrupt and EPC
//   ws_allowin         writeback may commit this cycle
//   ex_*               exception report to CP0 (ex_ex is a 1-cycle pulse)
//   eret_flush         1-cycle ERET pulse to CP0
//   flush              kill all younger pipeline stages
//   redirect_valid/_pc/_ready  new fetch PC handshake with fetch stage

module exc_commit_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic        ws_bd,
  input  logic        ws_fetch_adel,
  input  logic        ws_ri,
  input  logic        ws_ov,
  input  logic        ws_sys,
  input  logic        ws_bp,
  input  logic        ws_data_adel,
  input  logic        ws_data_ades,
  input  logic        ws_eret,
  input  logic [31:0] ws_badvaddr,
  input  logic        has_int,
  input  logic [31:0] epc,
  output logic        ws_allowin,
  output logic        ex_ex,
  output logic        ex_bd,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_excode,
  output logic [31:0] ex_badvaddr,
  output logic        eret_flush,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        int_s;
  logic        commit_s;
  logic        exc_s;
  logic        eret_s;
  logic [4:0]  excode_s;
  logic [31:0] badvaddr_s;

`ifdef EXC_INT_EN
  assign int_s = has_int;
`else
  logic unused_has_int_s;
  assign unused_has_int_s = has_int;
  assign int_s = 1'b0;
`endif

  // Commits only happen in IDLE, so has_int and flags are ignored in REDIR.
  assign commit_s       = ws_valid & ws_allowin;
  assign ws_allowin     = (state_r == IDLE);
  assign flush          = (state_r == REDIR);
  assign redirect_valid = (state_r == REDIR);

  // Priority encoder over the exception sources, highest first.
  always_comb begin
    excode_s   = 5'h00;
    badvaddr_s = 32'h0000_0000;
    exc_s      = 1'b1;
    if (int_s) begin
      excode_s = 5'h00;
    end else if (ws_fetch_adel) begin
      excode_s   = 5'h04;
      badvaddr_s = ws_pc;
    end else if (ws_ri) begin
      excode_s = 5'h0a;
    end else if (ws_ov) begin
      excode_s = 5'h0c;
    end else if (ws_sys) begin
      excode_s = 5'h08;
    end else if (ws_bp) begin
      excode_s = 5'h09;
    end else if (ws_data_adel) begin
      excode_s   = 5'h04;
      badvaddr_s = ws_badvaddr;
    end else if (ws_data_ades) begin
      excode_s   = 5'h05;
      badvaddr_s = ws_badvaddr;
    end else begin
      exc_s = 1'b0;
    end
  end

  // Any exception on the same instruction suppresses the ERET.
  assign eret_s = ws_eret & ~exc_s;

  // Next-state logic: enter REDIR on an event, leave on handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (commit_s & (exc_s | eret_s)) begin
          state_next_s = REDIR;
        end else begin
          state_next_s = IDLE;
        end
      end
      REDIR: begin
        if (redirect_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = REDIR;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // CP0 pulses, captured exception report and redirect target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ex       <= 1'b0;
      eret_flush  <= 1'b0;
      ex_bd       <= 1'b0;
      ex_pc       <= 32'h0000_0000;
      ex_excode   <= 5'h00;
      ex_badvaddr <= 32'h0000_0000;
      redirect_pc <= 32'h0000_0000;
    end else begin
      ex_ex      <= commit_s & exc_s;
      eret_flush <= commit_s & eret_s;
      if (commit_s & exc_s) begin
        ex_bd       <= ws_bd;
        ex_pc       <= ws_pc;
        ex_excode   <= excode_s;
        ex_badvaddr <= badvaddr_s;
        redirect_pc <= EXC_VECTOR;
      end else if (commit_s & eret_s) begin
        redirect_pc <= epc;
      end
    end
  end

endmodule
